// File: rtl/cfg_regfile_pkg.sv
// Shared constants, decode result type and parameter checks for the config register file.
package cfg_regfile_pkg;

  localparam logic [31:0] RO_OFF   = 32'h0000_0100;
  localparam logic [31:0] STAT_OFF = 32'h0000_0200;
  localparam logic [31:0] MASK_OFF = 32'h0000_0204;

  typedef enum logic [2:0] {
    DEC_RW,
    DEC_RO,
    DEC_STAT,
    DEC_MASK,
    DEC_BAD
  } dec_e;

  function automatic bit data_w_ok(input int w);
    return (w >= 8) && (w <= 32);
  endfunction

endpackage

// File: rtl/cfg_regfile_dec.sv
// Combinational address decode: byte address to register class and word index.
module cfg_regfile_dec
  import cfg_regfile_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                N_RW      = 8,
  parameter int                N_RO      = 4
) (
  input  logic [ADDR_W-1:0] addr,
  output dec_e              kind,
  output logic [5:0]        idx
);

  localparam logic [ADDR_W-1:0] RW_END = ADDR_W'(4 * N_RW);
  localparam logic [ADDR_W-1:0] RO_LO  = ADDR_W'(RO_OFF);
  localparam logic [ADDR_W-1:0] RO_HI  = ADDR_W'(RO_OFF + 32'(4 * N_RO));
  localparam logic [ADDR_W-1:0] STAT_A = ADDR_W'(STAT_OFF);
  localparam logic [ADDR_W-1:0] MASK_A = ADDR_W'(MASK_OFF);

  logic [ADDR_W-1:0] off;

  always_comb begin
    off  = addr - BASE_ADDR;
    kind = DEC_BAD;
    // RO_OFF has zero low byte, so off[7:2] is the word index in both windows
    idx  = off[7:2];
    if (off[1:0] == 2'b00) begin
      if (off < RW_END) begin
        kind = DEC_RW;
      end else if ((off >= RO_LO) && (off < RO_HI)) begin
        kind = DEC_RO;
      end else if (off == STAT_A) begin
        kind = DEC_STAT;
      end else if (off == MASK_A) begin
        kind = DEC_MASK;
      end
    end
  end

endmodule

// File: rtl/cfg_regfile.sv
// Parametrised config register file: RW controls, RO status, sticky W1C STATUS, MASK and irq.
module cfg_regfile
  import cfg_regfile_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                N_RW      = 8,
  parameter int                N_RO      = 4,
  parameter int                N_EVT     = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [DATA_W-1:0] RW_RST    = '0,
  parameter logic [31:0]       BAD_RDATA = 32'hDEAD_BEEF
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     wr,
  input  logic                     rd,
  output logic [DATA_W-1:0]        rdata,
  output logic                     rdata_vld,
  output logic                     rd_err,
  output logic                     wr_err,
  output logic [N_RW*DATA_W-1:0]   rw_out,
  output logic [N_RW-1:0]          rw_upd,
  input  logic [N_RO*DATA_W-1:0]   ro_in,
  input  logic [N_EVT-1:0]         evt_in,
  output logic                     irq
);

  localparam logic [DATA_W-1:0] BAD_V = BAD_RDATA[DATA_W-1:0];

  if (!data_w_ok(DATA_W)) begin : g_chk_dw
    $error("cfg_regfile: DATA_W out of range");
  end
  if (N_EVT > DATA_W) begin : g_chk_evt
    $error("cfg_regfile: N_EVT exceeds DATA_W");
  end
  if (BASE_ADDR[1:0] != 2'b00) begin : g_chk_base
    $error("cfg_regfile: BASE_ADDR not word aligned");
  end

  dec_e              dec_kind;
  logic [5:0]        dec_idx;
  logic [DATA_W-1:0] rw_arr [N_RW];
  logic [N_RW-1:0]   rw_upd_d, rw_upd_q;
  logic [N_EVT-1:0]  status_d, status_q, mask_d, mask_q;
  logic [DATA_W-1:0] rdata_d, rdata_q, rd_val;
  logic              rdata_vld_d, rdata_vld_q, rd_err_d, rd_err_q;
  logic              wr_err_d, wr_err_q, irq_d, irq_q;

  cfg_regfile_dec #(
    .ADDR_W   (ADDR_W),
    .BASE_ADDR(BASE_ADDR),
    .N_RW     (N_RW),
    .N_RO     (N_RO)
  ) u_dec (
    .addr(addr),
    .kind(dec_kind),
    .idx (dec_idx)
  );

  for (genvar gi = 0; gi < N_RW; gi++) begin : g_rw
    logic              hit;
    logic [DATA_W-1:0] rw_d, rw_q;

    assign hit = wr && (dec_kind == DEC_RW) && (dec_idx == 6'(gi));

    always_comb begin
      rw_d = rw_q;
      if (hit) rw_d = wdata;
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) rw_q <= RW_RST;
      else       rw_q <= rw_d;
    end

    assign rw_arr[gi]                    = rw_q;
    assign rw_out[gi*DATA_W +: DATA_W]   = rw_q;
    assign rw_upd_d[gi]                  = hit;
  end

  always_comb begin
    // a same-cycle event re-sets a bit the host is clearing
    status_d = status_q | evt_in;
    if (wr && (dec_kind == DEC_STAT)) status_d = (status_q & ~wdata[N_EVT-1:0]) | evt_in;
    mask_d = mask_q;
    if (wr && (dec_kind == DEC_MASK)) mask_d = wdata[N_EVT-1:0];
    irq_d    = |(status_d & mask_d);
    wr_err_d = wr && ((dec_kind == DEC_RO) || (dec_kind == DEC_BAD));

    // read mux sees current-state values, so a same-cycle write is not visible
    rd_val = BAD_V;
    case (dec_kind)
      DEC_RW: begin
        for (int i = 0; i < N_RW; i++) if (dec_idx == 6'(i)) rd_val = rw_arr[i];
      end
      DEC_RO: begin
        for (int i = 0; i < N_RO; i++) if (dec_idx == 6'(i)) rd_val = ro_in[i*DATA_W +: DATA_W];
      end
      DEC_STAT: rd_val = DATA_W'(status_q);
      DEC_MASK: rd_val = DATA_W'(mask_q);
      default:  rd_val = BAD_V;
    endcase

    rdata_d     = rd ? rd_val : rdata_q;
    rdata_vld_d = rd;
    rd_err_d    = rd && (dec_kind == DEC_BAD);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      status_q    <= '0;
      mask_q      <= '0;
      irq_q       <= 1'b0;
      wr_err_q    <= 1'b0;
      rw_upd_q    <= '0;
      rdata_q     <= '0;
      rdata_vld_q <= 1'b0;
      rd_err_q    <= 1'b0;
    end else begin
      status_q    <= status_d;
      mask_q      <= mask_d;
      irq_q       <= irq_d;
      wr_err_q    <= wr_err_d;
      rw_upd_q    <= rw_upd_d;
      rdata_q     <= rdata_d;
      rdata_vld_q <= rdata_vld_d;
      rd_err_q    <= rd_err_d;
    end
  end

  assign rdata     = rdata_q;
  assign rdata_vld = rdata_vld_q;
  assign rd_err    = rd_err_q;
  assign wr_err    = wr_err_q;
  assign rw_upd    = rw_upd_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_cfg_regfile.sv
// Self-checking bench for cfg_regfile: directed scenarios then random traffic against a map-level model.
module tb_cfg_regfile;

  localparam int          ADDR_W = 32;
  localparam int          DATA_W = 32;
  localparam int          N_RW   = 8;
  localparam int          N_RO   = 4;
  localparam int          N_EVT  = 8;
  localparam logic [31:0] BASE   = 32'h0000_4000;
  localparam logic [31:0] RST_V  = 32'h0000_005A;
  localparam logic [31:0] BAD_V  = 32'hDEAD_BEEF;

  logic                    clk = 1'b0;
  logic                    rstn = 1'b0;
  logic [ADDR_W-1:0]       addr = '0;
  logic [DATA_W-1:0]       wdata = '0;
  logic                    wr = 1'b0;
  logic                    rd = 1'b0;
  logic [DATA_W-1:0]       rdata;
  logic                    rdata_vld, rd_err, wr_err, irq;
  logic [N_RW*DATA_W-1:0]  rw_out;
  logic [N_RW-1:0]         rw_upd;
  logic [N_RO*DATA_W-1:0]  ro_in = '0;
  logic [N_EVT-1:0]        evt_in = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cfg_regfile #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .N_RW     (N_RW),
    .N_RO     (N_RO),
    .N_EVT    (N_EVT),
    .BASE_ADDR(BASE),
    .RW_RST   (RST_V),
    .BAD_RDATA(BAD_V)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .addr     (addr),
    .wdata    (wdata),
    .wr       (wr),
    .rd       (rd),
    .rdata    (rdata),
    .rdata_vld(rdata_vld),
    .rd_err   (rd_err),
    .wr_err   (wr_err),
    .rw_out   (rw_out),
    .rw_upd   (rw_upd),
    .ro_in    (ro_in),
    .evt_in   (evt_in),
    .irq      (irq)
  );

  // Reference state, kept as plain per-register values
  logic [31:0] rw_m [N_RW];
  logic [7:0]  status_m, mask_m;
  logic [31:0] exp_rdata;
  logic        exp_vld, exp_rderr, exp_wrerr;
  logic [7:0]  exp_upd;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_RW; i++) rw_m[i] = RST_V;
    status_m  = '0;
    mask_m    = '0;
    exp_rdata = '0;
    exp_vld   = 1'b0;
    exp_rderr = 1'b0;
    exp_wrerr = 1'b0;
    exp_upd   = '0;
  endtask

  // 0 = RW, 1 = RO, 2 = STATUS, 3 = MASK, 4 = unmapped
  function automatic int decode(input logic [31:0] a, output int idx);
    logic [31:0] off;
    off = a - BASE;
    idx = int'(off >> 2) % 64;
    if (off % 4 != 0) return 4;
    if (off < 32'(4 * N_RW)) return 0;
    if (off >= 32'h100 && off < 32'h100 + 32'(4 * N_RO)) begin
      idx = int'((off - 32'h100) >> 2);
      return 1;
    end
    if (off == 32'h200) return 2;
    if (off == 32'h204) return 3;
    return 4;
  endfunction

  task automatic check_outputs();
    check("rdata", 64'(rdata), 64'(exp_rdata));
    check("rdata_vld", 64'(rdata_vld), 64'(exp_vld));
    check("rd_err", 64'(rd_err), 64'(exp_rderr));
    check("wr_err", 64'(wr_err), 64'(exp_wrerr));
    check("rw_upd", 64'(rw_upd), 64'(exp_upd));
    check("irq", 64'(irq), 64'(|(status_m & mask_m)));
    for (int i = 0; i < N_RW; i++)
      check($sformatf("rw_out[%0d]", i), 64'(rw_out[i*DATA_W +: DATA_W]), 64'(rw_m[i]));
  endtask

  // One bus cycle: drive, predict from the pre-edge model state, clock, compare.
  task automatic bus(input logic w, input logic r, input logic [31:0] a,
                     input logic [31:0] d, input logic [7:0] ev);
    int          kind, idx;
    logic [31:0] ro_v [N_RO];
    logic [7:0]  clr;
    for (int j = 0; j < N_RO; j++) begin
      ro_v[j] = $urandom;
      ro_in[j*DATA_W +: DATA_W] = ro_v[j];
    end
    wr = w; rd = r; addr = a; wdata = d; evt_in = ev;
    kind = decode(a, idx);

    exp_vld   = r;
    exp_rderr = r && (kind == 4);
    if (r) begin
      case (kind)
        0:       exp_rdata = rw_m[idx];
        1:       exp_rdata = ro_v[idx];
        2:       exp_rdata = {24'h0, status_m};
        3:       exp_rdata = {24'h0, mask_m};
        default: exp_rdata = BAD_V;
      endcase
    end

    exp_upd   = '0;
    exp_wrerr = w && (kind == 1 || kind == 4);
    clr       = '0;
    if (w) begin
      case (kind)
        0: begin rw_m[idx] = d; exp_upd[idx] = 1'b1; end
        2: clr = d[7:0];
        3: mask_m = d[7:0];
        default: ;
      endcase
    end
    status_m = (status_m & ~clr) | ev;

    @(posedge clk);
    #1;
    $display("txn wr=%0b rd=%0b addr=%h wdata=%h evt=%h -> rdata=%h vld=%0b rd_err=%0b wr_err=%0b irq=%0b",
             w, r, a, d, ev, rdata, rdata_vld, rd_err, wr_err, irq);
    check_outputs();
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0, 1:    return BASE + 32'(4 * $urandom_range(0, N_RW - 1));
      2:       return BASE + 32'h100 + 32'(4 * $urandom_range(0, N_RO - 1));
      3:       return BASE + 32'h200;
      4:       return BASE + 32'h204;
      default: begin
        case ($urandom_range(0, 4))
          0:       return BASE + 32'(4 * N_RW);
          1:       return BASE + 32'h100 + 32'(4 * N_RO);
          2:       return BASE + 32'(4 * $urandom_range(0, N_RW - 1)) + 32'($urandom_range(1, 3));
          3:       return BASE + 32'h208;
          default: return BASE - 32'h4;
        endcase
      end
    endcase
  endfunction

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    #2 rstn = 1'b1;

    // Reset value readback, one read per cycle
    for (int i = 0; i < N_RW; i++) bus(1'b0, 1'b1, BASE + 32'(4 * i), 32'h0, 8'h0);
    bus(1'b0, 1'b0, BASE, 32'h0, 8'h0);

    // Single RW write and readback
    bus(1'b1, 1'b0, BASE + 32'h0C, 32'h1234_5678, 8'h0);
    bus(1'b0, 1'b1, BASE + 32'h0C, 32'h0, 8'h0);

    // Unmapped write, misaligned read, RO write
    bus(1'b1, 1'b0, BASE + 32'h0FC, 32'hFFFF_FFFF, 8'h0);
    bus(1'b0, 1'b1, BASE + 32'h102, 32'h0, 8'h0);
    bus(1'b1, 1'b0, BASE + 32'h100, 32'hFFFF_FFFF, 8'h0);
    bus(1'b0, 1'b1, BASE + 32'h100, 32'h0, 8'h0);

    // Event, mask, irq and set-beats-clear
    bus(1'b1, 1'b0, BASE + 32'h204, 32'h0000_0004, 8'h0);
    bus(1'b0, 1'b0, BASE, 32'h0, 8'h04);
    bus(1'b0, 1'b1, BASE + 32'h200, 32'h0, 8'h0);
    bus(1'b1, 1'b0, BASE + 32'h200, 32'h0000_0004, 8'h04);
    bus(1'b0, 1'b1, BASE + 32'h200, 32'h0, 8'h0);
    bus(1'b1, 1'b0, BASE + 32'h200, 32'h0000_0004, 8'h0);
    bus(1'b0, 1'b1, BASE + 32'h200, 32'h0, 8'h0);

    // Same-cycle write and read of RW[1]
    bus(1'b1, 1'b0, BASE + 32'h4, 32'h0000_0011, 8'h0);
    bus(1'b1, 1'b1, BASE + 32'h4, 32'h0000_00AA, 8'h0);
    bus(1'b0, 1'b1, BASE + 32'h4, 32'h0, 8'h0);

    // Random back-to-back traffic
    for (int n = 0; n < 300; n++) begin
      logic [7:0] ev;
      ev = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h0;
      bus(1'($urandom), 1'($urandom), rand_addr(), $urandom, ev);
    end

    // Reset asserted while a read is in flight
    bus(1'b1, 1'b0, BASE + 32'h8, 32'hCAFE_0001, 8'h0);
    bus(1'b0, 1'b1, BASE + 32'h8, 32'h0, 8'h0);
    wr = 1'b0; rd = 1'b1; addr = BASE; evt_in = '0;
    #3 rstn = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(posedge clk);
    #1;
    check("rdata_vld_after_rst", 64'(rdata_vld), 64'd0);
    check_outputs();
    rd = 1'b0;
    #2 rstn = 1'b1;
    bus(1'b0, 1'b1, BASE + 32'h8, 32'h0, 8'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
